// File: rtl/addsub_arb_pkg.sv
// ---------------------------------------------------------------------------
// addsub_arb_pkg
// Shared definitions for the two-requester add/subtract arbiter:
//   - DATA_W   : operand / result width (32)
//   - OP_ADD / OP_SUB : encoding of the reqN_sub operation select
//   - state_t  : arbiter FSM states (IDLE, EXEC, RESP)
//   - ovf_detect() : signed-overflow helper used when ADDSUB_ARB_OVF_EN
//                    is defined
// ---------------------------------------------------------------------------
package addsub_arb_pkg;

    localparam int DATA_W = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Signed overflow of a + b_eff: both addends carry the same sign but
    // the result sign differs.  For a subtract, b_eff is ~b, so its sign
    // bit is the inverted sign of b.
    function automatic logic ovf_detect(input logic a_msb,
                                        input logic b_eff_msb,
                                        input logic sum_msb);
        return (a_msb == b_eff_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_sub_32.sv
// ---------------------------------------------------------------------------
// add_sub_32
// 32-bit adder / subtractor shared by both requesters.
//   a, b   : operands
//   sel    : 0 = a + b, 1 = a - b (computed as a + ~b + 1)
//   sum    : result modulo 2^32
//   cout   : carry out of bit 31; on subtract 1 means no borrow
// ---------------------------------------------------------------------------
module add_sub_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sel,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] b_eff;
    logic [32:0] total;

    assign b_eff = sel ? ~b : b;

    // The +1 of the two's complement negate enters as the carry-in.
    assign total = {1'b0, a} + {1'b0, b_eff} + {32'd0, sel};

    assign sum  = total[31:0];
    assign cout = total[32];

endmodule

// File: rtl/addsub_arbiter.sv
// ---------------------------------------------------------------------------
// addsub_arbiter
// Round-robin arbiter that lets two requesters share one add_sub_32.
// Each accepted operation takes three cycles: IDLE (accept) -> EXEC
// (adder works on the captured operands) -> RESP (result held until the
// consumer takes it).
//
// Parameters
//   PRIO0_FIRST : 1 = requester 0 wins the first contended grant after
//                 reset, 0 = requester 1 wins it
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    : request handshake for requester N
//   reqN_a, reqN_b, reqN_sub   : operands and op select (0 add, 1 sub)
//   rsp_valid / rsp_ready      : response handshake
//   rsp_id                     : index of the requester that issued it
//   rsp_sum, rsp_cout, rsp_ovf : result, carry-out, signed overflow
//
// Build option
//   ADDSUB_ARB_OVF_EN : when defined, rsp_ovf reports signed overflow of
//                       the executed operation; otherwise rsp_ovf is 0 and
//                       no overflow logic exists.
// ---------------------------------------------------------------------------
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int PRIO0_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_sum,
    output logic        rsp_cout,
    output logic        rsp_ovf
);

    state_t state, state_nxt;

    // 1 = requester 1 wins the next contended cycle, 0 = requester 0 does.
    logic prio1;

    logic              accept;
    logic              acc_id;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_sub;
    logic              op_id;

    logic [DATA_W-1:0] add_sum;
    logic              add_cout;

    // ---------------------------------------------------------------
    // Grant selection and next state
    // ---------------------------------------------------------------
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        state_nxt  = state;

        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    req0_ready = !prio1;
                    req1_ready = prio1;
                end else begin
                    req0_ready = req0_valid;
                    req1_ready = req1_valid;
                end
                if (req0_valid || req1_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A ready is only ever raised alongside its valid, so either ready
    // marks an accepted request.
    assign accept    = req0_ready || req1_ready;
    assign acc_id    = req1_ready;
    assign rsp_valid = (state == RESP);

    // ---------------------------------------------------------------
    // State and round-robin pointer
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio1 <= (PRIO0_FIRST == 0);
        end else begin
            state <= state_nxt;
            if (accept) begin
                // Whoever was just served yields the next contention.
                prio1 <= !acc_id;
            end
        end
    end

    // ---------------------------------------------------------------
    // Operand capture on accept
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_sub <= OP_ADD;
            op_id  <= 1'b0;
        end else if (accept) begin
            op_a   <= acc_id ? req1_a   : req0_a;
            op_b   <= acc_id ? req1_b   : req0_b;
            op_sub <= acc_id ? req1_sub : req0_sub;
            op_id  <= acc_id;
        end
    end

    // ---------------------------------------------------------------
    // Shared adder, working on the captured operands during EXEC
    // ---------------------------------------------------------------
    add_sub_32 u_add_sub (
        .a    (op_a),
        .b    (op_b),
        .sel  (op_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // ---------------------------------------------------------------
    // Response registers, loaded on the EXEC -> RESP edge and held
    // untouched through RESP so a stalled consumer sees stable data
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id   <= 1'b0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
        end else if (state == EXEC) begin
            rsp_id   <= op_id;
            rsp_sum  <= add_sum;
            rsp_cout <= add_cout;
        end
    end

`ifdef ADDSUB_ARB_OVF_EN
    logic b_eff_msb;
    logic ovf_calc;

    assign b_eff_msb = (op_sub == OP_SUB) ? !op_b[DATA_W-1] : op_b[DATA_W-1];
    assign ovf_calc  = ovf_detect(op_a[DATA_W-1], b_eff_msb, add_sum[DATA_W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_ovf <= 1'b0;
        end else if (state == EXEC) begin
            rsp_ovf <= ovf_calc;
        end
    end
`else
    assign rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
    logic [31:0] rsp_sum;

    int tests = 0;
    int fails = 0;

    addsub_arbiter #(.PRIO0_FIRST(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_ovf    (rsp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          id;
        logic [31:0] a;
        logic [31:0] b;
        bit          sub;
        logic [31:0] exp_sum;
        bit          exp_cout;
        bit          exp_ovf;   // value when overflow reporting is built in
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit ovf_expected(input bit ovf);
`ifdef ADDSUB_ARB_OVF_EN
        return ovf;
`else
        return 1'b0 & ovf;
`endif
    endfunction

    // Reference arithmetic from plain integer math.
    task automatic ref_calc(input logic [31:0] a, input logic [31:0] b, input bit sub,
                            output logic [31:0] sum, output bit cout, output bit ovf);
        longint unsigned ua, ub, t;
        longint sa, sb, r;
        ua = a;
        ub = b;
        if (sub) begin
            sum  = a - b;
            cout = (ua >= ub);
        end else begin
            t    = ua + ub;
            sum  = t[31:0];
            cout = (t >= 64'h1_0000_0000);
        end
        sa = $signed(a);
        sb = $signed(b);
        r  = sub ? (sa - sb) : (sa + sb);
        ovf = ovf_expected((r > 64'sd2147483647) || (r < -64'sd2147483648));
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_sub = 0;
        req1_a = 0; req1_b = 0; req1_sub = 0;
        rsp_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        string tag;
        tag = $sformatf("vec%0d", idx);
        req0_valid = (v.id == 0); req1_valid = (v.id == 1);
        req0_a = v.id ? 32'h1234 : v.a; req0_b = v.id ? 32'h5 : v.b; req0_sub = v.id ? 1'b0 : v.sub;
        req1_a = v.id ? v.a : 32'h4321; req1_b = v.id ? v.b : 32'h6; req1_sub = v.id ? v.sub : 1'b1;
        rsp_ready = 1;
        n = 0;
        @(negedge clk);
        while (!(v.id ? req1_ready : req0_ready) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_grant_in_time"}, n < 10, 1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        check({tag, "_exec_no_rsp"}, rsp_valid, 0);
        @(negedge clk);
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_id"}, rsp_id, v.id);
        check({tag, "_sum"}, rsp_sum, v.exp_sum);
        check({tag, "_cout"}, rsp_cout, v.exp_cout);
        check({tag, "_ovf"}, rsp_ovf, ovf_expected(v.exp_ovf));
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_rsp_done"}, rsp_valid, 0);
    endtask

    initial begin
        logic [31:0] e_sum, h_sum;
        bit e_cout, e_ovf, e_id, h_cout, h_ovf, h_id;
        int got_ids[$];
        int n, mph;
        bit mprio1, e_r0, e_r1;
        logic [31:0] corner [5];

        vecs[0] = '{0, 32'd24,         32'd10, 1, 32'd14,         1, 0};
        vecs[1] = '{1, 32'hFFFF_FFFF,  32'd1,  0, 32'd0,          1, 0};
        vecs[2] = '{0, 32'h7FFF_FFFF,  32'd1,  0, 32'h8000_0000,  0, 1};
        vecs[3] = '{1, 32'd0,          32'd1,  1, 32'hFFFF_FFFF,  0, 0};
        vecs[4] = '{0, 32'h8000_0000,  32'd1,  1, 32'h7FFF_FFFF,  1, 1};
        vecs[5] = '{1, 32'd5,          32'd5,  1, 32'd0,          1, 0};
        corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h1;

        // Reset state, sampled while reset is held.
        idle_inputs();
        rst_n = 0;
        #12;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        check("rst_rsp_cout", rsp_cout, 0);
        check("rst_rsp_ovf", rsp_ovf, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        @(posedge clk); #1 rst_n = 1;

        // Both requesters valid continuously from reset: strict alternation.
        req0_valid = 1; req0_a = 32'd100; req0_b = 32'd1; req0_sub = 0;
        req1_valid = 1; req1_a = 32'd200; req1_b = 32'd2; req1_sub = 1;
        n = 0;
        while (got_ids.size() < 4 && n < 40) begin
            @(negedge clk);
            if (req0_ready && req1_ready) check("rr_one_ready", 1, 0);
            if (rsp_valid && rsp_ready) begin
                got_ids.push_back(int'(rsp_id));
                check("rr_sum", rsp_sum, rsp_id ? 32'd198 : 32'd101);
            end
            n++;
        end
        check("rr_count", got_ids.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_id%0d", i), (i < got_ids.size()) ? got_ids[i] : -1, i % 2);
        end
        do_reset();

        // Directed table.
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Consumer stall for three cycles in RESP with both requesters waiting.
        req0_valid = 1; req0_a = 32'd7; req0_b = 32'd9; req0_sub = 1;
        req1_valid = 1; req1_a = 32'd3; req1_b = 32'd4; req1_sub = 0;
        rsp_ready = 0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
        check("stall_rsp_reached", rsp_valid, 1);
        h_sum = rsp_sum; h_cout = rsp_cout; h_ovf = rsp_ovf; h_id = rsp_id;
        check("stall_first_id", h_id, 0);
        check("stall_first_sum", h_sum, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", rsp_valid, 1);
            check("stall_sum", rsp_sum, h_sum);
            check("stall_cout", rsp_cout, h_cout);
            check("stall_ovf", rsp_ovf, h_ovf);
            check("stall_id", rsp_id, h_id);
            check("stall_ready0", req0_ready, 0);
            check("stall_ready1", req1_ready, 0);
            @(negedge clk);
        end
        // Release: handshake cycle itself must accept nothing.
        rsp_ready = 1;
        #1;
        check("hs_ready0", req0_ready, 0);
        check("hs_ready1", req1_ready, 0);
        @(negedge clk);
        check("hs_single", rsp_valid, 0);
        check("hs_resume_ready1", req1_ready, 1);
        check("hs_resume_ready0", req0_ready, 0);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk); @(negedge clk);
        check("hs_next_rsp_id", rsp_id, 1);
        check("hs_next_rsp_sum", rsp_sum, 32'd7);
        @(posedge clk); #1;

        // Reset during EXEC aborts the transaction.
        req0_valid = 1; req0_a = 32'd55; req0_b = 32'd11; req0_sub = 0;
        n = 0;
        @(negedge clk);
        while (!req0_ready && n < 10) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req0_valid = 0;
        #2 rst_n = 0;
        #1;
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_rsp_id", rsp_id, 0);
        check("abort_rsp_sum", rsp_sum, 0);
        check("abort_rsp_cout", rsp_cout, 0);
        check("abort_rsp_ovf", rsp_ovf, 0);
        check("abort_ready0", req0_ready, 0);
        @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid, 0);
        end

        // Randomized traffic against a cycle-level reference.
        do_reset();
        mph = 0; mprio1 = 0;
        e_sum = 0; e_cout = 0; e_ovf = 0; e_id = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            e_r0 = (mph == 0) && req0_valid && (!req1_valid || !mprio1);
            e_r1 = (mph == 0) && req1_valid && (!req0_valid || mprio1);
            check("rnd_ready0", req0_ready, e_r0);
            check("rnd_ready1", req1_ready, e_r1);
            check("rnd_rsp_valid", rsp_valid, mph == 2);
            if (mph == 2) begin
                check("rnd_id", rsp_id, e_id);
                check("rnd_sum", rsp_sum, e_sum);
                check("rnd_cout", rsp_cout, e_cout);
                check("rnd_ovf", rsp_ovf, e_ovf);
            end
            if (mph == 0 && (e_r0 || e_r1)) begin
                if (e_r1) ref_calc(req1_a, req1_b, req1_sub, e_sum, e_cout, e_ovf);
                else      ref_calc(req0_a, req0_b, req0_sub, e_sum, e_cout, e_ovf);
                e_id = e_r1;
                mprio1 = e_r0;
                mph = 1;
            end else if (mph == 1) begin
                mph = 2;
            end else if (mph == 2 && rsp_ready) begin
                mph = 0;
            end
            @(posedge clk); #1;
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            req0_b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            req1_a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            req1_b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            req0_sub = $urandom_range(0, 1);
            req1_sub = $urandom_range(0, 1);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
